// File: rtl/poly_mult_loader.sv
// Host-side loader that moves bus words lane by lane into the POS/RB multiplier RAMs.
// Readback of both RAMs (modes 10/11) is compiled in only when POLY_LOADER_READBACK_EN is defined.
module poly_mult_loader #(
  parameter int unsigned BUS_W     = 128,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned POS_W     = 16,
  parameter int unsigned POS_DEPTH = 66,
  parameter int unsigned RB_W      = 32,
  parameter int unsigned RB_DEPTH  = 553
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [BUS_W-1:0]  key_i,
  input  logic [BUS_W-1:0]  data_i,
  output logic [BUS_W-1:0]  data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              pos_we_o,
  output logic [ADDR_W-1:0] pos_addr_o,
  output logic [POS_W-1:0]  pos_din_o,
  input  logic [POS_W-1:0]  pos_q_i,
  output logic              rb_we_o,
  output logic [ADDR_W-1:0] rb_addr_o,
  output logic [RB_W-1:0]   rb_din_o,
  input  logic [RB_W-1:0]   rb_q_i
);

  localparam int unsigned PosLanes = BUS_W / POS_W;
  localparam int unsigned RbLanes  = BUS_W / RB_W;
  localparam int unsigned MaxLanes = (PosLanes > RbLanes) ? PosLanes : RbLanes;
  localparam int unsigned CNT_W    = $clog2(MaxLanes) + 1;
  localparam int unsigned PosIdxW  = (PosLanes > 1) ? $clog2(PosLanes) : 1;
  localparam int unsigned RbIdxW   = (RbLanes > 1) ? $clog2(RbLanes) : 1;

  localparam logic [ADDR_W:0]  PosDepthW = (ADDR_W+1)'(POS_DEPTH);
  localparam logic [ADDR_W:0]  RbDepthW  = (ADDR_W+1)'(RB_DEPTH);
  localparam logic [CNT_W-1:0] PosLanesC = CNT_W'(PosLanes);
  localparam logic [CNT_W-1:0] RbLanesC  = CNT_W'(RbLanes);

`ifdef POLY_LOADER_READBACK_EN
  localparam bit RdEn = 1'b1;
`else
  localparam bit RdEn = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StWr, StRd, StRdLast, StDone} state_e;

  state_e             state_q, state_d;
  logic               sel_rb_q, sel_rb_d;
  logic [ADDR_W-1:0]  start_q, start_d;
  logic [BUS_W-1:0]   shadow_q, shadow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rd_pend_q, rd_pend_d;
  logic [CNT_W-1:0]   rd_lane_q, rd_lane_d;
  logic [BUS_W-1:0]   data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               pos_we_q, pos_we_d;
  logic [ADDR_W-1:0]  pos_addr_q, pos_addr_d;
  logic [POS_W-1:0]   pos_din_q, pos_din_d;
  logic               rb_we_q, rb_we_d;
  logic [ADDR_W-1:0]  rb_addr_q, rb_addr_d;
  logic [RB_W-1:0]    rb_din_q, rb_din_d;

  logic               unused_key;
  assign unused_key = ^key_i[BUS_W-3:ADDR_W];

  // Candidate lane: lane 0 of the incoming command in IDLE, otherwise the lane after cnt_q.
  logic               src_rb, src_rd;
  logic [ADDR_W-1:0]  src_start;
  logic [BUS_W-1:0]   src_data;
  logic [CNT_W-1:0]   lane;
  logic [ADDR_W:0]    lane_addr;
  logic               lane_last, lane_ovf, lane_ok;
  logic [PosIdxW-1:0] pos_idx, rd_pos_idx;
  logic [RbIdxW-1:0]  rb_idx, rd_rb_idx;
  logic [POS_W-1:0]   pos_lane;
  logic [RB_W-1:0]    rb_lane;
  logic               issue;

  always_comb begin
    if (state_q == StIdle) begin
      src_rb    = key_i[BUS_W-2];
      src_rd    = key_i[BUS_W-1];
      src_start = key_i[ADDR_W-1:0];
      src_data  = data_i;
      lane      = '0;
    end else begin
      src_rb    = sel_rb_q;
      src_rd    = (state_q != StWr);
      src_start = start_q;
      src_data  = shadow_q;
      lane      = cnt_q + CNT_W'(1);
    end
    lane_addr  = {1'b0, src_start} + (ADDR_W+1)'(lane);
    lane_last  = src_rb ? (lane >= RbLanesC) : (lane >= PosLanesC);
    lane_ovf   = lane_addr >= (src_rb ? RbDepthW : PosDepthW);
    lane_ok    = !lane_last && !lane_ovf;
    pos_idx    = lane[PosIdxW-1:0];
    rb_idx     = lane[RbIdxW-1:0];
    rd_pos_idx = rd_lane_q[PosIdxW-1:0];
    rd_rb_idx  = rd_lane_q[RbIdxW-1:0];
    pos_lane   = src_data[pos_idx*POS_W +: POS_W];
    rb_lane    = src_data[rb_idx*RB_W +: RB_W];
  end

  always_comb begin
    state_d    = state_q;
    sel_rb_d   = sel_rb_q;
    start_d    = start_q;
    shadow_d   = shadow_q;
    cnt_d      = cnt_q;
    rd_pend_d  = rd_pend_q;
    rd_lane_d  = rd_lane_q;
    data_d     = data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    pos_we_d   = 1'b0;
    pos_addr_d = pos_addr_q;
    pos_din_d  = pos_din_q;
    rb_we_d    = 1'b0;
    rb_addr_d  = rb_addr_q;
    rb_din_d   = rb_din_q;
    issue      = 1'b0;

    // Read data for the lane addressed last cycle arrives now.
    if ((state_q == StRd || state_q == StRdLast) && rd_pend_q) begin
      if (sel_rb_q) data_d[rd_rb_idx*RB_W +: RB_W] = rb_q_i;
      else          data_d[rd_pos_idx*POS_W +: POS_W] = pos_q_i;
    end

    case (state_q)
      StIdle: begin
        if (load_i) begin
          sel_rb_d  = src_rb;
          start_d   = src_start;
          shadow_d  = data_i;
          err_d     = 1'b0;
          data_d    = '0;
          rd_pend_d = 1'b0;
          if ((src_rd && !RdEn) || !lane_ok) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            issue   = 1'b1;
            busy_d  = 1'b1;
            state_d = src_rd ? StRd : StWr;
          end
        end
      end
      StWr: begin
        if (lane_ok) begin
          issue = 1'b1;
        end else begin
          err_d   = !lane_last;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      StRd: begin
        rd_pend_d = 1'b1;
        rd_lane_d = cnt_q;
        if (lane_ok) begin
          issue = 1'b1;
        end else begin
          err_d   = !lane_last;
          state_d = StRdLast;
        end
      end
      StRdLast: begin
        rd_pend_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        state_d   = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (issue) begin
      cnt_d = lane;
      if (src_rb) begin
        rb_addr_d = lane_addr[ADDR_W-1:0];
        if (!src_rd) begin
          rb_we_d  = 1'b1;
          rb_din_d = rb_lane;
          data_d[rb_idx*RB_W +: RB_W] = rb_lane;
        end
      end else begin
        pos_addr_d = lane_addr[ADDR_W-1:0];
        if (!src_rd) begin
          pos_we_d  = 1'b1;
          pos_din_d = pos_lane;
          data_d[pos_idx*POS_W +: POS_W] = pos_lane;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sel_rb_q   <= 1'b0;
      start_q    <= '0;
      shadow_q   <= '0;
      cnt_q      <= '0;
      rd_pend_q  <= 1'b0;
      rd_lane_q  <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      pos_we_q   <= 1'b0;
      pos_addr_q <= '0;
      pos_din_q  <= '0;
      rb_we_q    <= 1'b0;
      rb_addr_q  <= '0;
      rb_din_q   <= '0;
    end else begin
      state_q    <= state_d;
      sel_rb_q   <= sel_rb_d;
      start_q    <= start_d;
      shadow_q   <= shadow_d;
      cnt_q      <= cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_lane_q  <= rd_lane_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      pos_we_q   <= pos_we_d;
      pos_addr_q <= pos_addr_d;
      pos_din_q  <= pos_din_d;
      rb_we_q    <= rb_we_d;
      rb_addr_q  <= rb_addr_d;
      rb_din_q   <= rb_din_d;
    end
  end

  assign data_o     = data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign pos_we_o   = pos_we_q;
  assign pos_addr_o = pos_addr_q;
  assign pos_din_o  = pos_din_q;
  assign rb_we_o    = rb_we_q;
  assign rb_addr_o  = rb_addr_q;
  assign rb_din_o   = rb_din_q;

endmodule

// File: tb/tb_poly_mult_loader.sv
// Directed bench for poly_mult_loader with behavioural POS/RB RAMs (1-cycle read latency).
module tb_poly_mult_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_i;
  logic [127:0] key_i;
  logic [127:0] data_i;
  logic [127:0] data_o;
  logic         busy_o, done_o, err_o;
  logic         pos_we_o, rb_we_o;
  logic [9:0]   pos_addr_o, rb_addr_o;
  logic [15:0]  pos_din_o, pos_q;
  logic [31:0]  rb_din_o, rb_q;
  logic         mem_clr;

  logic [15:0]  pos_mem [66];
  logic [31:0]  rb_mem  [553];

  int n_vec = 0;
  int n_err = 0;
  int pos_wr = 0, rb_wr = 0, dones = 0, oob = 0;

  always #5 clk = ~clk;

  poly_mult_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_i),
    .key_i      (key_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .pos_we_o   (pos_we_o),
    .pos_addr_o (pos_addr_o),
    .pos_din_o  (pos_din_o),
    .pos_q_i    (pos_q),
    .rb_we_o    (rb_we_o),
    .rb_addr_o  (rb_addr_o),
    .rb_din_o   (rb_din_o),
    .rb_q_i     (rb_q)
  );

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 66; i++) pos_mem[i] <= 16'hDEAD;
      for (int i = 0; i < 553; i++) rb_mem[i] <= 32'hDEADBEEF;
    end else begin
      if (pos_we_o && pos_addr_o < 10'd66) pos_mem[pos_addr_o] <= pos_din_o;
      if (rb_we_o && rb_addr_o < 10'd553) rb_mem[rb_addr_o] <= rb_din_o;
    end
    pos_q <= (pos_addr_o < 10'd66) ? pos_mem[pos_addr_o] : 16'h0;
    rb_q  <= (rb_addr_o < 10'd553) ? rb_mem[rb_addr_o] : 32'h0;
  end

  always @(negedge clk) begin
    if (pos_we_o === 1'b1) pos_wr++;
    if (rb_we_o === 1'b1) rb_wr++;
    if (done_o === 1'b1) dones++;
    if ((pos_we_o === 1'b1 && pos_addr_o >= 10'd66) || (rb_we_o === 1'b1 && rb_addr_o >= 10'd553))
      oob++;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk_key(input logic [1:0] m, input logic [9:0] s);
    logic [127:0] k;
    k = '0;
    k[127:126] = m;
    k[9:0] = s;
    return k;
  endfunction

  // Returns in the first busy cycle (lane 0 on the RAM ports).
  task automatic issue(input logic [1:0] m, input logic [9:0] s, input logic [127:0] d);
    tick();
    key_i  = mk_key(m, s);
    data_i = d;
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
  endtask

  // Returns in the done_o cycle.
  task automatic wait_done(output int busy_cycles);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    busy_cycles = 0;
    while (!seen && n < 40) begin
      if (done_o === 1'b1) seen = 1'b1;
      else begin
        if (busy_o === 1'b1) busy_cycles++;
        tick();
        n++;
      end
    end
    check_eq("done_seen", 128'(seen), 128'd1);
  endtask

  int bc, p0, r0, d0;
  logic [127:0] d1, d2, d3, d5a, d6;

  initial begin
    rst = 1'b1; mem_clr = 1'b1; load_i = 1'b0; key_i = '0; data_i = '0;
    repeat (3) tick();
    check_eq("rst_busy",   128'(busy_o),   128'd0);
    check_eq("rst_done",   128'(done_o),   128'd0);
    check_eq("rst_err",    128'(err_o),    128'd0);
    check_eq("rst_pos_we", 128'(pos_we_o), 128'd0);
    check_eq("rst_rb_we",  128'(rb_we_o),  128'd0);
    check_eq("rst_data",   data_o,         128'd0);
    rst = 1'b0; mem_clr = 1'b0;
    tick();

    // 1: full POS write
    d1 = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    p0 = pos_wr; r0 = rb_wr; d0 = dones;
    issue(2'b00, 10'd0, d1);
    wait_done(bc);
    check_eq("t1_busy_cycles", 128'(bc), 128'd8);
    check_eq("t1_err", 128'(err_o), 128'd0);
    check_eq("t1_echo", data_o, d1);
    tick();
    check_eq("t1_pos_writes", 128'(pos_wr - p0), 128'd8);
    check_eq("t1_rb_writes", 128'(rb_wr - r0), 128'd0);
    check_eq("t1_dones", 128'(dones - d0), 128'd1);
    for (int k = 0; k < 8; k++) check_eq("t1_pos_mem", 128'(pos_mem[k]), 128'(k + 1));

    // 2: POS overflow at start 62
    d2 = 128'h1107_1106_1105_1104_1103_1102_1101_1100;
    p0 = pos_wr; d0 = dones;
    issue(2'b00, 10'd62, d2);
    wait_done(bc);
    check_eq("t2_busy_cycles", 128'(bc), 128'd4);
    check_eq("t2_err", 128'(err_o), 128'd1);
    check_eq("t2_echo", data_o, 128'h0000_0000_0000_0000_1103_1102_1101_1100);
    tick();
    check_eq("t2_pos_writes", 128'(pos_wr - p0), 128'd4);
    check_eq("t2_dones", 128'(dones - d0), 128'd1);
    check_eq("t2_mem61", 128'(pos_mem[61]), 128'h0000_DEAD);
    check_eq("t2_mem62", 128'(pos_mem[62]), 128'h1100);
    check_eq("t2_mem65", 128'(pos_mem[65]), 128'h1103);

    // 3: RB write up to the last entry
    d3 = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
    p0 = pos_wr; r0 = rb_wr;
    issue(2'b01, 10'd549, d3);
    wait_done(bc);
    check_eq("t3_err", 128'(err_o), 128'd0);
    check_eq("t3_busy_cycles", 128'(bc), 128'd4);
    tick();
    check_eq("t3_rb_writes", 128'(rb_wr - r0), 128'd4);
    check_eq("t3_pos_writes", 128'(pos_wr - p0), 128'd0);
    check_eq("t3_mem549", 128'(rb_mem[549]), 128'hAAAA_AAAA);
    check_eq("t3_mem552", 128'(rb_mem[552]), 128'hDDDD_DDDD);

    // 4: RB readback
    issue(2'b01, 10'd10, {32'd4, 32'd3, 32'd2, 32'd1});
    wait_done(bc);
    tick();
    r0 = rb_wr;
    issue(2'b11, 10'd10, 128'h0);
    wait_done(bc);
`ifdef POLY_LOADER_READBACK_EN
    check_eq("t4_busy_cycles", 128'(bc), 128'd5);
    check_eq("t4_err", 128'(err_o), 128'd0);
    check_eq("t4_data", data_o, {32'd4, 32'd3, 32'd2, 32'd1});
`else
    check_eq("t4_busy_cycles", 128'(bc), 128'd0);
    check_eq("t4_err", 128'(err_o), 128'd1);
    check_eq("t4_data", data_o, 128'd0);
    check_eq("t4_rb_addr", 128'(rb_addr_o), 128'd13);
`endif
    tick();
    check_eq("t4_rb_writes", 128'(rb_wr - r0), 128'd0);

    // 5: data_i change and second load during a write
    d5a = 128'h5507_5506_5505_5504_5503_5502_5501_5500;
    p0 = pos_wr; r0 = rb_wr; d0 = dones;
    issue(2'b00, 10'd20, d5a);
    tick();
    data_i = {128{1'b1}};
    key_i  = mk_key(2'b01, 10'd0);
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
    wait_done(bc);
    check_eq("t5_err", 128'(err_o), 128'd0);
    repeat (4) tick();
    check_eq("t5_pos_writes", 128'(pos_wr - p0), 128'd8);
    check_eq("t5_rb_writes", 128'(rb_wr - r0), 128'd0);
    check_eq("t5_dones", 128'(dones - d0), 128'd1);
    check_eq("t5_busy_after", 128'(busy_o), 128'd0);
    check_eq("t5_mem20", 128'(pos_mem[20]), 128'h5500);
    check_eq("t5_mem23", 128'(pos_mem[23]), 128'h5503);
    check_eq("t5_mem27", 128'(pos_mem[27]), 128'h5507);

    // 6: reset after lane 2
    d6 = 128'h6607_6606_6605_6604_6603_6602_6601_6600;
    p0 = pos_wr; d0 = dones;
    issue(2'b00, 10'd30, d6);
    tick();
    tick();
    check_eq("t6_lane2_addr", 128'(pos_addr_o), 128'd32);
    check_eq("t6_lane2_we", 128'(pos_we_o), 128'd1);
    rst = 1'b1;
    tick();
    check_eq("t6_rst_we", 128'(pos_we_o), 128'd0);
    check_eq("t6_rst_busy", 128'(busy_o), 128'd0);
    check_eq("t6_rst_done", 128'(done_o), 128'd0);
    rst = 1'b0;
    repeat (3) tick();
    check_eq("t6_dones", 128'(dones - d0), 128'd0);
    check_eq("t6_pos_writes", 128'(pos_wr - p0), 128'd3);
    check_eq("t6_mem32", 128'(pos_mem[32]), 128'h6602);
    check_eq("t6_mem33", 128'(pos_mem[33]), 128'hDEAD);
    issue(2'b01, 10'd0, 128'h0000_0000_0000_0000_0000_0000_7777_0001);
    wait_done(bc);
    check_eq("t6_new_err", 128'(err_o), 128'd0);
    tick();
    check_eq("t6_new_mem0", 128'(rb_mem[0]), 128'h7777_0001);

    check_eq("oob_writes", 128'(oob), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
